// File: rtl/s2p_deframer.sv
// LSB-first serial-to-parallel deframer with a single-entry valid/ready output register.
// Optional `PARITY_CHECK_EN adds a trailing even-parity bit per frame and drives par_err.
module s2p_deframer #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         ser_en,
  input  logic         ser_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] par_out,
  output logic         par_err,
  output logic         overflow,
  input  logic         clr_ovf
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d, word;
  logic          done, load, drop;
`ifdef PARITY_CHECK_EN
  logic          pbit;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    word    = sh_q;
`ifdef PARITY_CHECK_EN
    pbit    = 1'b0;
`endif
    if (start) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (ser_en) begin
            sh_d  = {ser_in, sh_q[N-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N-1)) begin
`ifdef PARITY_CHECK_EN
              state_d = PAR;
`else
              done    = 1'b1;
              word    = sh_d;
              state_d = IDLE;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        PAR: begin
          if (ser_en) begin
            done    = 1'b1;
            pbit    = ser_in;
            state_d = IDLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // a completing word loads if the register is empty or drains this cycle
  assign load = done & (~out_valid | out_ready);
  assign drop = done & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      par_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        par_out   <= word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_err <= 1'b0;
    else if (load)
      par_err <= pbit ^ (^word);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_deframer.sv
// Bench for s2p_deframer: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_s2p_deframer;
  localparam int N = 32;
`ifdef PARITY_CHECK_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, ser_en, ser_in;
  logic         out_ready, clr_ovf;
  logic         out_valid, par_err, overflow;
  logic [N-1:0] par_out;

  int n_cmp = 0;
  int n_bad = 0;

  s2p_deframer #(.N(N), .CW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ser_en(ser_en), .ser_in(ser_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .par_out(par_out), .par_err(par_err),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // model: frame bits collected in a queue, output register as plain vars
  logic         armed;
  logic         bits[$];
  logic         m_valid, m_ovf, m_perr;
  logic [N-1:0] m_word;
  logic         done, dropped, pb;
  logic [N-1:0] w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   = 1'b0;
      bits.delete();
      m_valid = 1'b0;
      m_word  = '0;
      m_ovf   = 1'b0;
      m_perr  = 1'b0;
    end else begin
      done    = 1'b0;
      dropped = 1'b0;
      pb      = 1'b0;
      w       = '0;
      if (start) begin
        armed = 1'b1;
        bits.delete();
      end else if (armed && ser_en) begin
        if (bits.size() < N) begin
          bits.push_back(ser_in);
          if (bits.size() == N && !HAS_PAR) done = 1'b1;
        end else begin
          done = 1'b1;
          pb   = ser_in;
        end
        if (done) begin
          armed = 1'b0;
          for (int i = 0; i < N; i++) w[i] = bits[i];
        end
      end
      if (done && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_word  = w;
        m_perr  = HAS_PAR && (pb != ^w);
      end else if (done) begin
        dropped = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valid", N'(out_valid), N'(m_valid));
    chk("par_out", par_out, m_word);
    chk("overflow", N'(overflow), N'(m_ovf));
    chk("par_err", N'(par_err), N'(m_perr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic e, logic b);
    start  = s;
    ser_en = e;
    ser_in = b;
    tick();
  endtask

  // start cycle deliberately carries ser_en=1 to prove no bit is sampled
  task automatic send_word(logic [N-1:0] v, logic p,
                           logic frc, logic rdy);
    logic [N-1:0] vv;
    vv = v;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      if (frc && !HAS_PAR && i == N-1) out_ready = rdy;
      drive(1'b0, 1'b1, vv[i]);
    end
    if (HAS_PAR) begin
      if (frc) out_ready = rdy;
      drive(1'b0, 1'b1, p);
    end
    ser_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", N'(out_valid), N'(0));
    chk("rst_par_out", par_out, '0);
    chk("rst_ovf", N'(overflow), N'(0));

    // ser_en in IDLE is ignored
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    chk("idle_valid", N'(out_valid), N'(0));

    // 1: basic word
    out_ready = 1'b1;
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", N'(out_valid), N'(1));
    chk("t1_word", par_out, 32'hDEADBEEF);
    chk("t1_ovf", N'(overflow), N'(0));
    chk("t1_perr", N'(par_err), N'(HAS_PAR ? ^32'hDEADBEEF : 0));
    tick();

    // 2: overflow while held
    out_ready = 1'b0;
    send_word(32'h00000001, 1'b1, 1'b0, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    chk("t2_word", par_out, 32'h00000001);
    chk("t2_ovf", N'(overflow), N'(1));
    chk("t2_valid", N'(out_valid), N'(1));
    out_ready = 1'b1;
    tick();
    chk("t2_drain", N'(out_valid), N'(0));
    out_ready = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_clr", N'(overflow), N'(0));

    // 3: accept and reload in the same cycle
    send_word(32'h00000005, 1'b0, 1'b0, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    chk("t3_valid", N'(out_valid), N'(1));
    chk("t3_word", par_out, 32'hA5A5A5A5);
    chk("t3_ovf", N'(overflow), N'(0));
    out_ready = 1'b1;
    tick();

    // 4: start aborts partial frame
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1);
    send_word(32'h12345678, 1'b1, 1'b0, 1'b0);
    chk("t4_word", par_out, 32'h12345678);
    chk("t4_valid", N'(out_valid), N'(1));

    // 5: reset mid-frame
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b1);
    ser_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", N'(out_valid), N'(0));
    chk("t5_rst_word", par_out, '0);
    chk("t5_rst_ovf", N'(overflow), N'(0));
    chk("t5_rst_perr", N'(par_err), N'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_word(32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    chk("t5_word", par_out, 32'h0000FFFF);
    tick();

    // 6: parity result
    send_word(32'h00000003, 1'b0, 1'b0, 1'b0);
    chk("t6_perr0", N'(par_err), N'(0));
    tick();
    send_word(32'h00000003, 1'b1, 1'b0, 1'b0);
    chk("t6_perr1", N'(par_err), N'(HAS_PAR ? 1 : 0));
    tick();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      out_ready = ($urandom_range(0, 99) < 45);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 99) < 80),
            1'($urandom));
      if (c == 2500) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    start = 1'b0; ser_en = 1'b0; clr_ovf = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
